// File: rtl/reset_sequencer_if.sv
// Request/status bundle between a reset controller and the reset sequencer.
// The sequencer side uses the slave modport; the controller or bench uses master.
interface reset_sequencer_if #(
    parameter int NUM_CH = 4
);
    logic              i_sw_rst_req;
    logic              i_wdt_rst;
    logic [NUM_CH-1:0] o_rstn;
    logic              o_ready;
    logic              o_busy;
    logic [1:0]        o_cause;

    modport master (
        output i_sw_rst_req,
        output i_wdt_rst,
        input  o_rstn,
        input  o_ready,
        input  o_busy,
        input  o_cause
    );

    modport slave (
        input  i_sw_rst_req,
        input  i_wdt_rst,
        output o_rstn,
        output o_ready,
        output o_busy,
        output o_cause
    );
endinterface

// File: rtl/reset_sequencer.sv
// Synchronised external reset release, hold stretch and ordered per-domain release,
// with software/watchdog soft resets and a sticky reset-cause record.
module reset_sequencer #(
    parameter int SYNC_DEPTH = 5,
    parameter int NUM_CH     = 4,
    parameter int STRETCH    = 16,
    parameter int STAGE_GAP  = 8
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    reset_sequencer_if.slave   bus
);
    localparam int REL_SPAN = STAGE_GAP * (NUM_CH - 1);
    localparam int CNT_MAX  = (STRETCH > REL_SPAN) ? STRETCH : REL_SPAN;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  STRETCH_LAST = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [NUM_CH-1:0] CH_NONE      = {NUM_CH{1'b0}};
    localparam logic [NUM_CH-1:0] CH_ALL       = {NUM_CH{1'b1}};
    localparam logic [NUM_CH-1:0] CH_FIRST     = NUM_CH'(1'b1);

    localparam logic [1:0] CAUSE_EXT = 2'd0;
    localparam logic [1:0] CAUSE_SW  = 2'd1;
    localparam logic [1:0] CAUSE_WDT = 2'd2;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // Watchdog outranks software when both request in the same cycle.
    function automatic logic [1:0] soft_cause(input logic wdt);
        logic [1:0] c;
        if (wdt) begin
            c = CAUSE_WDT;
        end else begin
            c = CAUSE_SW;
        end
        return c;
    endfunction

    logic [SYNC_DEPTH-1:0] sync_r;
    state_t                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [NUM_CH-1:0]     rstn_r, rstn_s;
    logic                  ready_r, busy_r;
    logic [1:0]            cause_r, cause_s;
    logic                  soft_req_s;

    assign soft_req_s = bus.i_sw_rst_req | bus.i_wdt_rst;

    // Deassertion synchroniser for the external reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_r <= {SYNC_DEPTH{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_DEPTH-2:0], 1'b1};
        end
    end

    // Next-state, counter, channel mask and cause.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        rstn_s  = rstn_r;
        cause_s = cause_r;
        case (state_r)
            ST_SYNC: begin
                rstn_s = CH_NONE;
                cnt_s  = CNT_ZERO;
                if (sync_r[SYNC_DEPTH-1]) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_SYNC;
                end
            end
            ST_HOLD: begin
                if (cnt_r == STRETCH_LAST) begin
                    rstn_s  = CH_FIRST;
                    cnt_s   = CNT_ZERO;
                    state_s = (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    rstn_s  = CH_NONE;
                    cnt_s   = cnt_r + CNT_ONE;
                    state_s = ST_HOLD;
                end
            end
            ST_RELEASE: begin
                // Channels release as a thermometer code growing from bit 0.
                if (cnt_r == GAP_LAST) begin
                    rstn_s = (rstn_r << 1'b1) | CH_FIRST;
                    cnt_s  = CNT_ZERO;
                    if (&rstn_s) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_RELEASE;
                    end
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                    state_s = ST_RELEASE;
                end
            end
            ST_RUN: begin
                rstn_s  = CH_ALL;
                cnt_s   = CNT_ZERO;
                state_s = ST_RUN;
            end
            default: begin
                rstn_s  = CH_NONE;
                cnt_s   = CNT_ZERO;
                state_s = ST_SYNC;
            end
        endcase
        if ((state_r != ST_SYNC) && soft_req_s) begin
            state_s = ST_HOLD;
            cnt_s   = CNT_ZERO;
            rstn_s  = CH_NONE;
            cause_s = soft_cause(bus.i_wdt_rst);
        end else begin
            cause_s = cause_r;
        end
    end

    // State and counter registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r <= ST_SYNC;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Registered outputs; external reset always wins the cause record.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rstn_r  <= CH_NONE;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            cause_r <= CAUSE_EXT;
        end else begin
            rstn_r  <= rstn_s;
            ready_r <= (state_s == ST_RUN);
            busy_r  <= (state_s == ST_HOLD) || (state_s == ST_RELEASE);
            cause_r <= cause_s;
        end
    end

    assign bus.o_rstn  = rstn_r;
    assign bus.o_ready = ready_r;
    assign bus.o_busy  = busy_r;
    assign bus.o_cause = cause_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: default configuration plus a minimal
// NUM_CH=1/STRETCH=1/STAGE_GAP=1/SYNC_DEPTH=2 instance.
module tb_reset_sequencer;
    typedef struct packed {
        logic [3:0] rstn;
        logic       ready;
        logic       busy;
        logic [1:0] cause;
    } exp_t;

    logic clk_s = 1'b0;
    logic rstn_a_s;
    logic rstn_b_s;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t got_s;
    exp_t exp_s;

    reset_sequencer_if #(.NUM_CH(4)) bus_a ();
    reset_sequencer_if #(.NUM_CH(1)) bus_b ();

    reset_sequencer u_dut_a (
        .i_clk  (clk_s),
        .i_rstn (rstn_a_s),
        .bus    (bus_a.slave)
    );

    reset_sequencer #(
        .SYNC_DEPTH (2),
        .NUM_CH     (1),
        .STRETCH    (1),
        .STAGE_GAP  (1)
    ) u_dut_b (
        .i_clk  (clk_s),
        .i_rstn (rstn_b_s),
        .bus    (bus_b.slave)
    );

    always #5 clk_s = ~clk_s;

    // Expected outputs e edges after the external reset rises.
    function automatic exp_t exp_por(input int e);
        exp_t r;
        for (int k = 0; k < 4; k++) r.rstn[k] = (e >= 22 + 8 * k);
        r.ready = (e >= 46);
        r.busy  = (e >= 6) && (e < 46);
        r.cause = 2'd0;
        return r;
    endfunction

    // Expected outputs e edges after the soft-reset sampling edge.
    function automatic exp_t exp_soft(input int e, input logic [1:0] c);
        exp_t r;
        for (int k = 0; k < 4; k++) r.rstn[k] = (e >= 16 + 8 * k);
        r.ready = (e >= 40);
        r.busy  = (e < 40);
        r.cause = c;
        return r;
    endfunction

    function automatic exp_t obs_a();
        return {bus_a.o_rstn, bus_a.o_ready, bus_a.o_busy, bus_a.o_cause};
    endfunction

    function automatic exp_t obs_b();
        return {3'b000, bus_b.o_rstn, bus_b.o_ready, bus_b.o_busy, bus_b.o_cause};
    endfunction

    // One-edge request pulse on DUT A, queueing n expected post-edge states.
    task automatic pulse_a(input logic sw, input logic wdt, input logic [1:0] c, input int n);
        bus_a.i_sw_rst_req = sw;
        bus_a.i_wdt_rst    = wdt;
        @(posedge clk_s);
        #1;
        bus_a.i_sw_rst_req = 1'b0;
        bus_a.i_wdt_rst    = 1'b0;
        for (int e = 0; e < n; e++) sb_q.push_back(exp_soft(e, c));
    endtask

    task automatic test_reset;
        rstn_a_s = 1'b0;
        rstn_b_s = 1'b0;
        bus_a.i_sw_rst_req = 1'b0;
        bus_a.i_wdt_rst    = 1'b0;
        bus_b.i_sw_rst_req = 1'b0;
        bus_b.i_wdt_rst    = 1'b0;
        repeat (3) @(negedge clk_s);
        sb_q.push_back(exp_t'(8'h00));
        got_s = obs_a();
        exp_s = sb_q.pop_front();
        checks++;
        if (got_s !== exp_s) begin
            errors++;
            $display("FAIL reset_state got=%b expected=%b", got_s, exp_s);
        end
    endtask

    task automatic test_por;
        rstn_a_s = 1'b1;
        for (int e = 1; e <= 50; e++) sb_q.push_back(exp_por(e));
        for (int e = 1; e <= 50; e++) begin
            @(posedge clk_s);
            @(negedge clk_s);
            got_s = obs_a();
            exp_s = sb_q.pop_front();
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL por edge=%0d got=%b expected=%b", e, got_s, exp_s);
            end
        end
    endtask

    task automatic test_sw_reset;
        pulse_a(1'b1, 1'b0, 2'd1, 45);
        for (int e = 0; e < 45; e++) begin
            if (e != 0) @(posedge clk_s);
            @(negedge clk_s);
            got_s = obs_a();
            exp_s = sb_q.pop_front();
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL sw_reset edge=T+%0d got=%b expected=%b", e, got_s, exp_s);
            end
        end
    endtask

    task automatic test_sw_wdt_same_cycle;
        pulse_a(1'b1, 1'b1, 2'd2, 45);
        for (int e = 0; e < 45; e++) begin
            if (e != 0) @(posedge clk_s);
            @(negedge clk_s);
            got_s = obs_a();
            exp_s = sb_q.pop_front();
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL sw_wdt_both edge=T+%0d got=%b expected=%b", e, got_s, exp_s);
            end
        end
    endtask

    task automatic test_wdt_mid_release;
        pulse_a(1'b1, 1'b0, 2'd1, 26);
        for (int e = 0; e < 26; e++) begin
            if (e != 0) @(posedge clk_s);
            @(negedge clk_s);
            got_s = obs_a();
            exp_s = sb_q.pop_front();
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL pre_wdt edge=T+%0d got=%b expected=%b", e, got_s, exp_s);
            end
        end
        // Outputs now read 4'b0011; the watchdog must re-assert the released domains.
        pulse_a(1'b0, 1'b1, 2'd2, 45);
        for (int e = 0; e < 45; e++) begin
            if (e != 0) @(posedge clk_s);
            @(negedge clk_s);
            got_s = obs_a();
            exp_s = sb_q.pop_front();
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL wdt_mid_release edge=T+%0d got=%b expected=%b", e, got_s, exp_s);
            end
        end
    endtask

    task automatic test_ext_reset_in_hold;
        pulse_a(1'b1, 1'b0, 2'd1, 6);
        for (int e = 0; e < 6; e++) begin
            if (e != 0) @(posedge clk_s);
            @(negedge clk_s);
            got_s = obs_a();
            exp_s = sb_q.pop_front();
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL hold_before_ext edge=T+%0d got=%b expected=%b", e, got_s, exp_s);
            end
        end
        rstn_a_s = 1'b0;
        sb_q.push_back(exp_t'(8'h00));
        #1;
        got_s = obs_a();
        exp_s = sb_q.pop_front();
        checks++;
        if (got_s !== exp_s) begin
            errors++;
            $display("FAIL ext_async_assert got=%b expected=%b", got_s, exp_s);
        end
        @(negedge clk_s);
        test_por();
    endtask

    task automatic test_min_config;
        exp_t e_v;
        sb_q.push_back(exp_t'(8'h00));
        got_s = obs_b();
        exp_s = sb_q.pop_front();
        checks++;
        if (got_s !== exp_s) begin
            errors++;
            $display("FAIL min_reset_state got=%b expected=%b", got_s, exp_s);
        end
        rstn_b_s = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            e_v.rstn  = {3'b000, (e >= 4)};
            e_v.ready = (e >= 4);
            e_v.busy  = (e == 3);
            e_v.cause = 2'd0;
            sb_q.push_back(e_v);
        end
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk_s);
            @(negedge clk_s);
            got_s = obs_b();
            exp_s = sb_q.pop_front();
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL min_por edge=%0d got=%b expected=%b", e, got_s, exp_s);
            end
        end
        bus_b.i_sw_rst_req = 1'b1;
        for (int e = 0; e < 10; e++) sb_q.push_back(exp_t'(8'b0000_0_1_01));
        for (int e = 0; e < 10; e++) begin
            @(posedge clk_s);
            @(negedge clk_s);
            got_s = obs_b();
            exp_s = sb_q.pop_front();
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL min_sw_held cycle=%0d got=%b expected=%b", e, got_s, exp_s);
            end
        end
        bus_b.i_sw_rst_req = 1'b0;
        for (int e = 0; e < 2; e++) sb_q.push_back(exp_t'(8'b0001_1_0_01));
        for (int e = 0; e < 2; e++) begin
            @(posedge clk_s);
            @(negedge clk_s);
            got_s = obs_b();
            exp_s = sb_q.pop_front();
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL min_sw_drop edge=%0d got=%b expected=%b", e, got_s, exp_s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_por();
        test_sw_reset();
        test_sw_wdt_same_cycle();
        test_wdt_mid_release();
        test_ext_reset_in_hold();
        test_min_config();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
